instruction_fetch_stage: RTL and testbench

Pipeline stage directly upstream of instruction decode. Owns the fetch PC and issues word reads to a synchronous instruction memory with one-cycle read latency. Buffers returned words in a 2-entry FIFO so decode stalls lose no instructions. Presents {instruction, PC, valid} to decode and takes branch/jump redirects from later stages.

---
 rtl/instruction_fetch_stage_if.sv | 27 ++
 rtl/instruction_fetch_stage.sv | 78 +++++++
 tb/tb_instruction_fetch_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: instruction memory read port plus the decode-side
// instruction/stall/redirect signals, bundled so the stage and its environment share one port.
interface instruction_fetch_stage_if;
  logic [31:0] imemAddress;
  logic        imemReadEnable;
  logic [31:0] imemReadData;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] instruction;
  logic [31:0] instructionPC;
  logic        instructionValid;

  // Handshake: an instruction transfers to decode in a cycle where
  // instructionValid = 1, stall = 0 and redirect = 0. While stall = 1 the head
  // stays stable. The memory answers a read with imemReadEnable = 1 on
  // imemReadData in the following cycle, with no backpressure.
  modport master (
    output imemAddress, imemReadEnable, instruction, instructionPC, instructionValid,
    input  imemReadData, stall, redirect, redirectTarget
  );

  modport slave (
    input  imemAddress, imemReadEnable, instruction, instructionPC, instructionValid,
    output imemReadData, stall, redirect, redirectTarget
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch: owns fetchPC, reads a one-cycle-latency instruction memory,
// and buffers returned words in a 2-entry FIFO in front of decode.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h00000000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013
) (
  input logic                        clk,
  input logic                        rst,
  instruction_fetch_stage_if.master  fetchBus
);

  logic [31:0] fetchPC;
  logic        inflight;
  logic [31:0] inflightPC;
  logic [31:0] fifoWord [2];
  logic [31:0] fifoPC   [2];
  logic        headIdx;
  logic [1:0]  count;

  logic        valid;
  logic        pop;
  logic        push;
  logic        issue;
  logic        tailIdx;
  logic [2:0]  creditUsed;

  assign valid = !rst && (count != 2'd0);
  assign pop   = valid && !fetchBus.stall && !fetchBus.redirect;
  assign push  = inflight && !fetchBus.redirect && !rst;

  // Credits count buffered plus in-flight words, so every issued read has a
  // FIFO slot waiting for it one cycle later.
  assign creditUsed = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = !rst && !fetchBus.redirect && (creditUsed < 3'd2);

  // With two entries, head + count (mod 2) is the tail; when full the tail
  // aliases the head, which is only written while that head is being popped.
  assign tailIdx = headIdx ^ count[0];

  assign fetchBus.imemAddress      = fetchPC;
  assign fetchBus.imemReadEnable   = issue;
  assign fetchBus.instructionValid = valid;
  assign fetchBus.instruction      = valid ? fifoWord[headIdx] : NOP_INSTRUCTION;
  assign fetchBus.instructionPC    = valid ? fifoPC[headIdx]   : 32'h00000000;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPC    <= RESET_PC;
      inflight   <= 1'b0;
      inflightPC <= 32'h00000000;
      headIdx    <= 1'b0;
      count      <= 2'd0;
    end else if (fetchBus.redirect) begin
      fetchPC  <= {fetchBus.redirectTarget[31:2], 2'b00};
      inflight <= 1'b0;
      headIdx  <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (issue) begin
        inflight   <= 1'b1;
        inflightPC <= fetchPC;
        fetchPC    <= fetchPC + 32'd4;
      end else begin
        inflight <= 1'b0;
      end
      headIdx <= headIdx ^ pop;
      count   <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoWord[tailIdx] <= fetchBus.imemReadData;
      fifoPC[tailIdx]   <= inflightPC;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: memory returns word = address;
// a monitor scores every accepted instruction against an expected queue.
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  logic rstB;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_qb[$];

  instruction_fetch_stage_if busA ();
  instruction_fetch_stage_if busB ();

  instruction_fetch_stage #(.RESET_PC(32'h00000000), .NOP_INSTRUCTION(NOP)) dutA (
    .clk(clk), .rst(rst), .fetchBus(busA.master)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFFFFF8), .NOP_INSTRUCTION(NOP)) dutB (
    .clk(clk), .rst(rstB), .fetchBus(busB.master)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // synchronous memories: word = address, one-cycle latency
  always @(posedge clk) begin
    if (busA.imemReadEnable) busA.imemReadData <= busA.imemAddress;
    if (busB.imemReadEnable) busB.imemReadData <= busB.imemAddress;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, pc});
  endtask

  task automatic expect_pc_b(input logic [31:0] pc);
    exp_qb.push_back({pc, pc});
  endtask

  // monitors: score every instruction decode accepts
  always @(negedge clk) begin
    if (busA.instructionValid && !busA.stall && !busA.redirect) begin
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monA_unexpected: actual pc=%h instr=%h required=none",
                 busA.instructionPC, busA.instruction);
      end else begin
        e = exp_q.pop_front();
        if ({busA.instruction, busA.instructionPC} !== e) begin
          errors++;
          $display("FAIL monA_word: actual instr=%h pc=%h required instr=%h pc=%h",
                   busA.instruction, busA.instructionPC, e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (busB.instructionValid && !busB.stall && !busB.redirect) begin
      logic [63:0] e;
      checks++;
      if (exp_qb.size() == 0) begin
        errors++;
        $display("FAIL monB_unexpected: actual pc=%h instr=%h required=none",
                 busB.instructionPC, busB.instruction);
      end else begin
        e = exp_qb.pop_front();
        if ({busB.instruction, busB.instructionPC} !== e) begin
          errors++;
          $display("FAIL monB_word: actual instr=%h pc=%h required instr=%h pc=%h",
                   busB.instruction, busB.instructionPC, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    rstB = 1'b1;
    busA.stall = 1'b0; busA.redirect = 1'b0; busA.redirectTarget = 32'h0;
    busB.stall = 1'b0; busB.redirect = 1'b0; busB.redirectTarget = 32'h0;
    busA.imemReadData = 32'h0;
    busB.imemReadData = 32'h0;
    repeat (3) step();

    @(negedge clk);
    check("rst_re", {31'b0, busA.imemReadEnable}, 32'd0);
    check("rst_valid", {31'b0, busA.instructionValid}, 32'd0);
    check("rst_instr", busA.instruction, NOP);
    check("rst_pc", busA.instructionPC, 32'h0);
    check("rstB_valid", {31'b0, busB.instructionValid}, 32'd0);

    // C0: leave reset, first issue immediately
    step(); rst = 1'b0; rstB = 1'b0;
    expect_pc(32'h0); expect_pc(32'h4);
    expect_pc_b(32'hFFFFFFF8); expect_pc_b(32'hFFFFFFFC);
    expect_pc_b(32'h00000000); expect_pc_b(32'h00000004);
    @(negedge clk);
    check("c0_re", {31'b0, busA.imemReadEnable}, 32'd1);
    check("c0_addr", busA.imemAddress, 32'h0);
    check("c0_valid", {31'b0, busA.instructionValid}, 32'd0);
    check("c0_addrB", busB.imemAddress, 32'hFFFFFFF8);
    // C1
    step(); @(negedge clk);
    check("c1_valid", {31'b0, busA.instructionValid}, 32'd0);
    check("c1_addr", busA.imemAddress, 32'h4);
    // C2, C3: PCs 0 and 4 accepted
    step(); step();
    // C4..C6: stall with head PC 8
    step(); busA.stall = 1'b1; @(negedge clk);
    check("stall1_pc", busA.instructionPC, 32'h8);
    check("stall1_re", {31'b0, busA.imemReadEnable}, 32'd0);
    step(); @(negedge clk);
    check("stall2_pc", busA.instructionPC, 32'h8);
    check("stall2_re", {31'b0, busA.imemReadEnable}, 32'd0);
    step(); busB.stall = 1'b1; @(negedge clk);
    check("stall3_pc", busA.instructionPC, 32'h8);
    check("stall3_instr", busA.instruction, 32'h8);
    check("stall3_re", {31'b0, busA.imemReadEnable}, 32'd0);
    expect_pc(32'h8); expect_pc(32'hC);
    // C7, C8: drain 8, 12
    step(); busA.stall = 1'b0;
    step();
    // C9: redirect to 0x100 while 0x14 is in flight
    step(); busA.redirect = 1'b1; busA.redirectTarget = 32'h100; @(negedge clk);
    check("c9_head", busA.instructionPC, 32'h10);
    check("c9_re", {31'b0, busA.imemReadEnable}, 32'd0);
    expect_pc(32'h100); expect_pc(32'h104);
    step(); busA.redirect = 1'b0; @(negedge clk);
    check("rd1_valid", {31'b0, busA.instructionValid}, 32'd0);
    check("rd1_re", {31'b0, busA.imemReadEnable}, 32'd1);
    check("rd1_addr", busA.imemAddress, 32'h100);
    step(); @(negedge clk);
    check("rd2_valid", {31'b0, busA.instructionValid}, 32'd0);
    // C12, C13: 0x100, 0x104 accepted
    step(); step();
    // C14: stall until full, C15: redirect to unaligned 0x103
    step(); busA.stall = 1'b1;
    step(); busA.redirect = 1'b1; busA.redirectTarget = 32'h103; @(negedge clk);
    check("full_head", busA.instructionPC, 32'h108);
    check("full_re", {31'b0, busA.imemReadEnable}, 32'd0);
    expect_pc(32'h100); expect_pc(32'h104);
    step(); busA.redirect = 1'b0; busA.stall = 1'b0; @(negedge clk);
    check("rd3_addr", busA.imemAddress, 32'h100);
    check("rd3_re", {31'b0, busA.imemReadEnable}, 32'd1);
    check("rd3_valid", {31'b0, busA.instructionValid}, 32'd0);
    step(); @(negedge clk);
    check("rd4_valid", {31'b0, busA.instructionValid}, 32'd0);
    // C18, C19: 0x100, 0x104 accepted
    step(); step();
    // C20: reset with a word buffered and a request in flight
    step(); busA.stall = 1'b1; rst = 1'b1; @(negedge clk);
    check("mrst_valid", {31'b0, busA.instructionValid}, 32'd0);
    check("mrst_re", {31'b0, busA.imemReadEnable}, 32'd0);
    check("mrst_instr", busA.instruction, NOP);
    check("mrst_pc", busA.instructionPC, 32'h0);
    expect_pc(32'h0); expect_pc(32'h4);
    step(); rst = 1'b0; busA.stall = 1'b0; @(negedge clk);
    check("post_rst_valid", {31'b0, busA.instructionValid}, 32'd0);
    check("post_rst_addr", busA.imemAddress, 32'h0);
    check("post_rst_re", {31'b0, busA.imemReadEnable}, 32'd1);
    step(); @(negedge clk);
    check("stale_drop_valid", {31'b0, busA.instructionValid}, 32'd0);
    check("stale_drop_addr", busA.imemAddress, 32'h4);
    // C23, C24: 0, 4 accepted; then hold decode stalled
    step(); step();
    step(); busA.stall = 1'b1;
    repeat (3) step();

    check("expA_left", exp_q.size(), 32'd0);
    check("expB_left", exp_qb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
